// File: rtl/mpsoc_msi_wb_initiator.sv
// Wishbone classic initiator: valid/ready command stream in, single bus cycles out, response stream back.
// Optional bus-error termination is enabled with `define MPSOC_MSI_WB_INITIATOR_ERR_EN.
module mpsoc_msi_wb_initiator #(
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          wbm_clk,
   input  logic          wbm_rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_adr,
   input  logic [31:0]   cmd_dat,
   input  logic [3:0]    cmd_sel,
   input  logic          cmd_we,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_dat,
   output logic          rsp_err,
   output logic          rsp_tmo,
   output logic [AW-1:0] wbm_adr_o,
   output logic [31:0]   wbm_dat_o,
   output logic [3:0]    wbm_sel_o,
   output logic          wbm_we_o,
   output logic          wbm_cyc_o,
   output logic          wbm_stb_o,
   input  logic [31:0]   wbm_dat_i,
`ifdef MPSOC_MSI_WB_INITIATOR_ERR_EN
   input  logic          wbm_err_i,
`endif
   input  logic          wbm_ack_i
);

   localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

   state_t          state_q, state_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [31:0]     rsp_dat_q, rsp_dat_d;
   logic            rsp_err_q, rsp_err_d;
   logic            rsp_tmo_q, rsp_tmo_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [31:0]     dat_q, dat_d;
   logic [3:0]      sel_q, sel_d;
   logic            we_q, we_d;
   logic            cyc_q, cyc_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            err_c;
   logic            tmo_hit_c;

`ifdef MPSOC_MSI_WB_INITIATOR_ERR_EN
   assign err_c = wbm_err_i;
`else
   assign err_c = 1'b0;
`endif

   assign tmo_hit_c = (TIMEOUT != 0) && (timer_q == TMO_LAST);

   // Next-state and registered-output logic; termination priority is ack > err > timeout.
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      rsp_tmo_d   = rsp_tmo_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      we_d        = we_q;
      cyc_d       = cyc_q;
      timer_d     = timer_q;
      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               adr_d       = cmd_adr;
               dat_d       = cmd_dat;
               sel_d       = cmd_sel;
               we_d        = cmd_we;
               cyc_d       = 1'b1;
               timer_d     = '0;
               cmd_ready_d = 1'b0;
               state_d     = BUS;
            end
         end
         BUS: begin
            if (wbm_ack_i) begin
               rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_tmo_d   = 1'b0;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end else if (err_c) begin
               rsp_dat_d   = 32'd0;
               rsp_err_d   = 1'b1;
               rsp_tmo_d   = 1'b0;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end else if (tmo_hit_c) begin
               rsp_dat_d   = 32'd0;
               rsp_err_d   = 1'b0;
               rsp_tmo_d   = 1'b1;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end else if (TIMEOUT != 0) begin
               timer_d = timer_q + TW'(1);
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wbm_clk) begin
      if (!wbm_rst_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         rsp_tmo_q   <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         cyc_q       <= 1'b0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         rsp_tmo_q   <= rsp_tmo_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         cyc_q       <= cyc_d;
         timer_q     <= timer_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_tmo   = rsp_tmo_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign wbm_sel_o = sel_q;
   assign wbm_we_o  = we_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;

endmodule
